simple_stream_fifo: RTL and testbench

SIMPLE_STREAM_FIFO -- requirements
Module: simple_stream_fifo

---
 rtl/simple_stream_fifo.sv | 86 ++++++++
 tb/tb_simple_stream_fifo.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/simple_stream_fifo.sv
// rtl/simple_stream_fifo.sv - first-word fall-through stream FIFO with flush and sticky overflow
// Occupancy is tracked in an explicit counter, so full and empty never depend on comparing pointers.
module simple_stream_fifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             wr_en, rd_en;

    // Handshake qualifiers come only from registered state, never from the opposite port.
    assign in_ready    = (count_q != CW'(DEPTH));
    assign out_valid   = (count_q != '0);
    assign out_data    = mem_q[rd_ptr_q];
    assign count       = count_q;
    assign almost_full = (count_q >= CW'(AF_LEVEL));
    assign overflow    = overflow_q;

    assign wr_en = in_valid && in_ready;
    assign rd_en = out_valid && out_ready;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q || (in_valid && !in_ready);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately left out of reset; out_data is only meaningful with out_valid.
    always_ff @(posedge clk) begin
        if (wr_en && !flush) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end
endmodule

// File: tb/tb_simple_stream_fifo.sv
// tb/tb_simple_stream_fifo.sv - randomized scoreboard bench for simple_stream_fifo
module tb_simple_stream_fifo;
    localparam int W     = 8;
    localparam int DEPTH = 16;
    localparam int AF    = DEPTH - 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic [4:0]   count;
    logic         almost_full;
    logic         overflow;

    int           checks = 0;
    int           errors = 0;
    int           mcnt = 0;
    int           movf = 0;
    logic [W-1:0] exp_q[$];

    simple_stream_fifo #(.WIDTH(W), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .almost_full(almost_full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every read handshake the DUT presents must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && !flush && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL underflow pop with empty scoreboard at %0t", $time);
            end else begin
                chk("out_data", int'(out_data), int'(exp_q.pop_front()));
            end
        end
    end

    // One clock cycle: apply inputs, check registered state, then advance the model.
    task automatic step(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
        bit acc, pop;
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        chk("count", int'(count), mcnt);
        chk("in_ready", int'(in_ready), int'(mcnt != DEPTH));
        chk("out_valid", int'(out_valid), int'(mcnt != 0));
        chk("almost_full", int'(almost_full), int'(mcnt >= AF));
        chk("overflow", int'(overflow), movf);
        acc = iv && (mcnt != DEPTH);
        pop = ordy && (mcnt != 0);
        if (iv && !acc) movf = 1;
        if (fl) begin
            mcnt = 0;
            exp_q.delete();
        end else begin
            if (acc) exp_q.push_back(d);
            mcnt = mcnt + int'(acc) - int'(pop);
        end
    endtask

    // Called right after step() returns; reset lands between edges and the following edge may write.
    task automatic pulse_reset(input logic wr, input logic [W-1:0] d);
        #1;
        rst_n     = 1'b0;
        in_valid  = wr;
        in_data   = d;
        out_ready = 1'b0;
        flush     = 1'b0;
        #1;
        chk("rst_count", int'(count), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_almost_full", int'(almost_full), 0);
        #1;
        rst_n = 1'b1;
        mcnt  = int'(wr);
        movf  = 0;
        exp_q.delete();
        if (wr) exp_q.push_back(d);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        pulse_reset(1'b0, '0);

        for (int i = 1; i <= DEPTH; i++) step(1'b1, W'(i), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        drain();
        step(1'b0, '0, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) step(1'b1, W'(8'h30 + i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b1, W'(8'h60 + i), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        drain();

        for (int i = 0; i < DEPTH; i++) step(1'b1, W'(8'h80 + i), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        drain();

        for (int i = 0; i < 20; i++) step(1'b1, W'(8'hC0 + i), 1'b1, 1'b0);
        drain();

        for (int i = 0; i < 5; i++) step(1'b1, W'(8'h10 + i), 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);

        for (int i = 0; i < 7; i++) step(1'b1, W'(8'h40 + i), 1'b0, 1'b0);
        pulse_reset(1'b1, 8'h5A);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);

        for (int i = 0; i < 2000; i++) begin
            int wr_pct, rd_pct;
            wr_pct = ((i / 100) % 2 == 0) ? 80 : 35;
            rd_pct = ((i / 100) % 2 == 0) ? 35 : 80;
            step(($urandom_range(99) < wr_pct), W'($urandom),
                 ($urandom_range(99) < rd_pct), ($urandom_range(63) == 0));
            if (i == 1000) pulse_reset(1'($urandom_range(1)), W'($urandom));
        end
        drain();
        step(1'b0, '0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
